// File: rtl/lsfr_rand_arbiter_if.sv
// lsfr_rand_arbiter_if
//   Request/grant bundle between REQ requesters and the random-priority
//   arbiter.
//   req      : per-requester level request          (master -> slave)
//   done     : current owner releases the resource   (master -> slave)
//   grant    : one-hot registered grant              (slave -> master)
//   grant_id : binary index of grant, 0 when idle    (slave -> master)
//   busy     : resource owned, equals |grant         (slave -> master)
interface lsfr_rand_arbiter_if #(
  parameter int unsigned REQ = 4
);
  localparam int unsigned IDW = $clog2(REQ);

  logic [REQ-1:0] req;
  logic           done;
  logic [REQ-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic           busy;

  modport master (output req, done, input grant, grant_id, busy);
  modport slave  (input req, done, output grant, grant_id, busy);
endinterface

// File: rtl/lsfr_rand_arbiter.sv
// lsfr_rand_arbiter
//   Shares one resource between REQ requesters. On each arbitration the scan
//   start index is taken from the low bits of a free-running Fibonacci LFSR,
//   so priority is randomised and lockstep request patterns cannot starve a
//   requester systematically. A grant is held until the owner asserts done or
//   drops its request; at least one idle cycle separates owners.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : lsfr_rand_arbiter_if.slave (req, done in; grant, grant_id, busy out)
//   Optional feature, macro LSFR_ARB_STARVE_GUARD_EN:
//     per-requester saturating wait counters; a requester whose counter has
//     reached MAX_WAIT is urgent and the lowest-index urgent requester wins
//     the next arbitration regardless of the LFSR start. MAX_WAIT exists only
//     in that build.
module lsfr_rand_arbiter #(
  parameter int unsigned REQ    = 4,
  parameter int unsigned LSFR_W = 8
`ifdef LSFR_ARB_STARVE_GUARD_EN
  , parameter int unsigned MAX_WAIT = 15
`endif
) (
  input  logic               clk,
  input  logic               reset,
  lsfr_rand_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(REQ);

  // Maximal-length feedback masks (bit n-1 set for tap n).
  function automatic logic [15:0] lsfr_taps(input int unsigned w);
    case (w)
      3:       lsfr_taps = 16'h0006;
      4:       lsfr_taps = 16'h000C;
      5:       lsfr_taps = 16'h0014;
      6:       lsfr_taps = 16'h0030;
      7:       lsfr_taps = 16'h0060;
      8:       lsfr_taps = 16'h00B8;
      9:       lsfr_taps = 16'h0110;
      10:      lsfr_taps = 16'h0240;
      11:      lsfr_taps = 16'h0500;
      12:      lsfr_taps = 16'h0829;
      13:      lsfr_taps = 16'h100D;
      14:      lsfr_taps = 16'h2015;
      15:      lsfr_taps = 16'h6000;
      default: lsfr_taps = 16'hD008;
    endcase
  endfunction

  localparam logic [15:0] TAPS = lsfr_taps(LSFR_W);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [LSFR_W-1:0] lsfr_q, lsfr_d;
  logic [REQ-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              busy_q, busy_d;

  logic [IDW-1:0]    start;
  logic [IDW-1:0]    idx;
  logic              pick_found;
  logic [IDW-1:0]    pick_id;
  logic [IDW-1:0]    win_id;

  always_comb begin
    lsfr_d = {lsfr_q[LSFR_W-2:0], ^(lsfr_q & TAPS[LSFR_W-1:0])};
  end

  // Rotating scan from the LFSR start; REQ is a power of two so the index
  // wraps by plain truncation.
  always_comb begin
    start      = lsfr_q[IDW-1:0];
    idx        = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx = start + k[IDW-1:0];
      if (!pick_found && bus.req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

`ifdef LSFR_ARB_STARVE_GUARD_EN
  localparam int unsigned   CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0]  wait_q [REQ];
  logic [CW-1:0]  wait_d [REQ];
  logic [REQ-1:0] urgent;
  logic           urgent_found;
  logic [IDW-1:0] urgent_id;

  // Urgency also requires a live request so a requester that withdrew in
  // the arbitration cycle can never be granted.
  always_comb begin
    urgent_found = 1'b0;
    urgent_id    = '0;
    for (int unsigned i = 0; i < REQ; i++) begin
      urgent[i] = (wait_q[i] == WAIT_MAX) && bus.req[i];
      if (bus.req[i] && !grant_q[i])
        wait_d[i] = (wait_q[i] == WAIT_MAX) ? wait_q[i] : wait_q[i] + 1'b1;
      else
        wait_d[i] = '0;
      if (!urgent_found && urgent[i]) begin
        urgent_found = 1'b1;
        urgent_id    = i[IDW-1:0];
      end
    end
    win_id = urgent_found ? urgent_id : pick_id;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '{default: '0};
    else       wait_q <= wait_d;
  end
`else
  always_comb begin
    win_id = pick_id;
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        grant_d    = '0;
        grant_id_d = '0;
        if (pick_found) begin
          state_d         = GRANT;
          grant_d[win_id] = 1'b1;
          grant_id_d      = win_id;
        end
      end
      GRANT: begin
        if (bus.done || !bus.req[grant_id_q]) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lsfr_q     <= {{(LSFR_W-1){1'b0}}, 1'b1};
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lsfr_q     <= lsfr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
endmodule
